// File: rtl/io_mux_arbiter.sv
// io_mux_arbiter: round-robin owner arbitration for one shared io_mux pin.
// While no requester owns the pin, func_select presents a receive function.
// While requester k owns it, func_select = RXCOUNT+k. Every release is followed
// by GUARD turnaround cycles in DEFAULT_RX, so two drivers never swap directly.
//
// Ports:
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   req          per-requester level-sensitive transmit requests
//   rx_sel       receive function shown while idle (clamped to DEFAULT_RX)
//   grant        one-hot owner, or zero
//   func_select  io_mux function select
//   busy         high while granted or in turnaround
//
// Optional feature macro: IO_MUX_ARBITER_TIMEOUT_EN
//   When defined, an owner that has held for MAXHOLD cycles loses the pin
//   as soon as another requester is waiting.
module io_mux_arbiter #(
   parameter int unsigned RXCOUNT    = 2,
   parameter int unsigned TXCOUNT    = 3,
   parameter int unsigned GUARD      = 4,
   parameter int unsigned DEFAULT_RX = 0,
   parameter int unsigned MAXHOLD    = 16,
   localparam int unsigned FWIDTH    = $clog2(RXCOUNT + TXCOUNT + 1)
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [TXCOUNT-1:0] req,
   input  logic [FWIDTH-1:0]  rx_sel,
   output logic [TXCOUNT-1:0] grant,
   output logic [FWIDTH-1:0]  func_select,
   output logic               busy
);

   localparam int unsigned LW = (TXCOUNT > 1) ? $clog2(TXCOUNT) : 1;
   localparam int unsigned CW = (GUARD > 1) ? $clog2(GUARD) : 1;

   // Elaboration-time parameter sanity check
   if (TXCOUNT == 0 || RXCOUNT == 0 || MAXHOLD == 0 || DEFAULT_RX >= RXCOUNT) begin : g_param_check
      $error("io_mux_arbiter: illegal parameter set");
   end

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_GRANT = 2'd1,
      S_TURN  = 2'd2
   } state_e;

   state_e             state_q, state_d;
   logic [TXCOUNT-1:0] grant_q, grant_d;
   logic [FWIDTH-1:0]  func_q, func_d;
   logic               busy_q, busy_d;
   logic [LW-1:0]      last_q, last_d;
   logic [CW-1:0]      cnt_q, cnt_d;

`ifdef IO_MUX_ARBITER_TIMEOUT_EN
   localparam int unsigned HW = $clog2(MAXHOLD + 1);
   logic [HW-1:0] hold_q, hold_d;
`endif

   // Round-robin winner: first set req bit scanning last+1, last+2, ...
   logic          win_found;
   logic [LW-1:0] win_idx;
   int unsigned   idx;

   always_comb begin
      win_found = 1'b0;
      win_idx   = '0;
      idx       = 0;
      for (int unsigned i = 1; i <= TXCOUNT; i++) begin
         idx = (32'(last_q) + i) % TXCOUNT;
         if (!win_found && req[LW'(idx)]) begin
            win_found = 1'b1;
            win_idx   = LW'(idx);
         end
      end
   end

   // Next-state and registered-output logic
   logic release_c;

   always_comb begin
      state_d   = state_q;
      grant_d   = grant_q;
      func_d    = func_q;
      busy_d    = busy_q;
      last_d    = last_q;
      cnt_d     = cnt_q;
      release_c = 1'b0;
`ifdef IO_MUX_ARBITER_TIMEOUT_EN
      hold_d    = hold_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (win_found) begin
               state_d = S_GRANT;
               grant_d = TXCOUNT'(1) << win_idx;
               func_d  = FWIDTH'(RXCOUNT) + FWIDTH'(win_idx);
               last_d  = win_idx;
               busy_d  = 1'b1;
`ifdef IO_MUX_ARBITER_TIMEOUT_EN
               hold_d  = '0;
`endif
            end else begin
               grant_d = '0;
               busy_d  = 1'b0;
               func_d  = (rx_sel < FWIDTH'(RXCOUNT)) ? rx_sel : FWIDTH'(DEFAULT_RX);
            end
         end
         S_GRANT: begin
            release_c = !req[last_q];
`ifdef IO_MUX_ARBITER_TIMEOUT_EN
            // Forced release only when someone else is waiting; otherwise saturate
            if (hold_q == HW'(MAXHOLD - 1)) begin
               if ((req & ~grant_q) != '0) release_c = 1'b1;
            end else begin
               hold_d = hold_q + HW'(1);
            end
`endif
            if (release_c) begin
               grant_d = '0;
               func_d  = FWIDTH'(DEFAULT_RX);
               if (GUARD > 0) begin
                  cnt_d   = CW'(GUARD - 1);
                  state_d = S_TURN;
                  busy_d  = 1'b1;
               end else begin
                  state_d = S_IDLE;
                  busy_d  = 1'b0;
               end
            end
         end
         S_TURN: begin
            grant_d = '0;
            func_d  = FWIDTH'(DEFAULT_RX);
            busy_d  = 1'b1;
            if (cnt_q == '0) begin
               state_d = S_IDLE;
               busy_d  = 1'b0;
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         default: begin
            state_d = S_IDLE;
            grant_d = '0;
            func_d  = FWIDTH'(DEFAULT_RX);
            busy_d  = 1'b0;
         end
      endcase
   end

   // State and output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         grant_q <= '0;
         func_q  <= FWIDTH'(DEFAULT_RX);
         busy_q  <= 1'b0;
         last_q  <= LW'(TXCOUNT - 1);
         cnt_q   <= '0;
`ifdef IO_MUX_ARBITER_TIMEOUT_EN
         hold_q  <= '0;
`endif
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         func_q  <= func_d;
         busy_q  <= busy_d;
         last_q  <= last_d;
         cnt_q   <= cnt_d;
`ifdef IO_MUX_ARBITER_TIMEOUT_EN
         hold_q  <= hold_d;
`endif
      end
   end

   assign grant       = grant_q;
   assign func_select = func_q;
   assign busy        = busy_q;

endmodule
